// File: rtl/flopr_pipe_pkg.sv
// Shared constants for the flopr_pipe register pipeline.
// The id-to-label helper exists only when FLOPR_PIPE_TRACE_EN is defined.
package flopr_pkg;

  localparam logic [2:0] FLOPR_ID_DATA   = 3'b000;
  localparam logic [2:0] FLOPR_ID_RD1    = 3'b001;
  localparam logic [2:0] FLOPR_ID_RD2    = 3'b010;
  localparam logic [2:0] FLOPR_ID_ALUOUT = 3'b011;

  localparam int FLOPR_PIPE_MAX_DEPTH = 8;

`ifdef FLOPR_PIPE_TRACE_EN
  function automatic string flopr_label(input logic [2:0] id);
    case (id)
      FLOPR_ID_DATA:   return "DATA";
      FLOPR_ID_RD1:    return "RD1";
      FLOPR_ID_RD2:    return "RD2";
      FLOPR_ID_ALUOUT: return "ALUOut";
      default:         return "PIPE";
    endcase
  endfunction
`endif

endpackage

// File: rtl/flopr_pipe_stage.sv
// One valid+data register of flopr_pipe. Data loads only with a valid word,
// so a bubble clears the valid bit but keeps the previous data.
module flopr_pipe_stage
  import flopr_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             flush,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
    end else if (load) begin
      q_valid <= d_valid;
      if (d_valid) q_data <= d_data;
    end
  end

endmodule

// File: rtl/flopr_pipe.sv
// DEPTH-stage stallable, flushable register pipeline with valid/ready handshake
// and bubble collapse. Optional trace output under FLOPR_PIPE_TRACE_EN.
module flopr_pipe
  import flopr_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       id,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1 || DEPTH > FLOPR_PIPE_MAX_DEPTH) begin : g_bad_depth
    $error("flopr_pipe: DEPTH out of range 1..8");
  end

  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] dat [DEPTH];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] occ;

  // A stage may advance when it is empty or the stage ahead advances;
  // this lets words slide into holes while the tail is stalled.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = !vld[DEPTH-1] | out_ready;
    for (int unsigned k = 1; k < DEPTH; k++) begin
      adv[DEPTH-1-k] = !vld[DEPTH-1-k] | adv[DEPTH-k];
    end
  end

  assign in_ready  = adv[0] & !flush;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_fire  = out_valid & out_ready;
  assign occupancy = occ;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             d_valid;
    logic [WIDTH-1:0] d_data;

    if (k == 0) begin : g_head
      assign d_valid = in_valid;
      assign d_data  = in_data;
    end else begin : g_body
      assign d_valid = vld[k-1];
      assign d_data  = dat[k-1];
    end

    flopr_pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .load    (adv[k]),
      .flush   (flush),
      .d_valid (d_valid),
      .d_data  (d_data),
      .q_valid (vld[k]),
      .q_data  (dat[k])
    );
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else if (in_fire && !out_fire) begin
      occ <= occ + 1'b1;
    end else if (!in_fire && out_fire) begin
      occ <= occ - 1'b1;
    end
  end

`ifdef FLOPR_PIPE_TRACE_EN
  logic [CNT_W-1:0] dropped;
  assign dropped = occ - CNT_W'(out_fire);

  always_ff @(posedge clk) begin
    if (reset) begin
      if (in_fire)
        $display("%s in  occ=%0d data=%h", flopr_label(id), occ, in_data);
      if (out_fire)
        $display("%s out occ=%0d data=%h", flopr_label(id), occ, out_data);
      if (flush && dropped != '0)
        $display("%s flush dropped=%0d", flopr_label(id), dropped);
    end
  end
`else
  logic unused_id;
  assign unused_id = ^id;
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// Directed bench for flopr_pipe: vector table on a DEPTH=2 instance plus
// hand-written sequences on DEPTH=1 and DEPTH=8 instances.
module tb_flopr_pipe;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  // DEPTH=2 instance
  logic        fl2, iv2, ir2, ov2, or2;
  logic [31:0] id2, od2;
  logic [1:0]  oc2;
  // DEPTH=1 instance
  logic        fl1, iv1, ir1, ov1, or1;
  logic [31:0] id1, od1;
  logic [0:0]  oc1;
  // DEPTH=8 instance
  logic        fl8, iv8, ir8, ov8, or8;
  logic [31:0] id8, od8;
  logic [3:0]  oc8;

  flopr_pipe #(.WIDTH(32), .DEPTH(2)) dut2 (
    .clk(clk), .reset(rst), .id(3'b001), .flush(fl2),
    .in_valid(iv2), .in_ready(ir2), .in_data(id2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .occupancy(oc2));

  flopr_pipe #(.WIDTH(32), .DEPTH(1)) dut1 (
    .clk(clk), .reset(rst), .id(3'b000), .flush(fl1),
    .in_valid(iv1), .in_ready(ir1), .in_data(id1),
    .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(oc1));

  flopr_pipe #(.WIDTH(32), .DEPTH(8)) dut8 (
    .clk(clk), .reset(rst), .id(3'b111), .flush(fl8),
    .in_valid(iv8), .in_ready(ir8), .in_data(id8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .occupancy(oc8));

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        flush;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        erdy;
    logic        eov;
    logic [31:0] eod;
    logic [31:0] eocc;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic r, input logic f, input logic v, input logic [31:0] d,
                              input logic o, input logic er, input logic eo,
                              input logic [31:0] ed, input logic [31:0] ec);
    vec_t t;
    t = '{rst: r, flush: f, iv: v, d: d, ordy: o, erdy: er, eov: eo, eod: ed, eocc: ec};
    tbl.push_back(t);
  endfunction

  task automatic edge_s();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    fl2 = 0; iv2 = 0; id2 = '0; or2 = 0;
    fl1 = 0; iv1 = 0; id1 = '0; or1 = 0;
    fl8 = 0; iv8 = 0; id8 = '0; or8 = 0;

    //   rst fl iv data          ordy rdy ov od            occ
    // streaming
    add(1, 0, 1, 32'h11111111, 1,  1,  0, 32'h0,        0+1);
    add(1, 0, 1, 32'h22222222, 1,  1,  1, 32'h11111111, 2);
    add(1, 0, 1, 32'h33333333, 1,  1,  1, 32'h22222222, 2);
    add(1, 0, 0, 32'h0,        1,  1,  1, 32'h33333333, 1);
    add(1, 0, 0, 32'h0,        1,  1,  0, 32'h33333333, 0);
    // back-pressure, full, one-cycle release
    add(1, 0, 1, 32'hA,        0,  1,  0, 32'h33333333, 1);
    add(1, 0, 1, 32'hB,        0,  1,  1, 32'hA,        2);
    add(1, 0, 1, 32'hC,        0,  0,  1, 32'hA,        2);
    add(1, 0, 1, 32'hC,        1,  1,  1, 32'hB,        2);
    add(1, 0, 0, 32'h0,        1,  1,  1, 32'hC,        1);
    add(1, 0, 0, 32'h0,        1,  1,  0, 32'hC,        0);
    // bubble collapse with a gap
    add(1, 0, 1, 32'h5,        0,  1,  0, 32'hC,        1);
    add(1, 0, 0, 32'h0,        0,  1,  1, 32'h5,        1);
    add(1, 0, 1, 32'h6,        0,  1,  1, 32'h5,        2);
    add(1, 0, 1, 32'h99,       0,  0,  1, 32'h5,        2);
    // flush while full, with a pending input word
    add(1, 1, 1, 32'h7,        0,  0,  0, 32'h5,        0);
    add(1, 0, 0, 32'h0,        1,  1,  0, 32'h5,        0);
    // flush coinciding with an output transfer
    add(1, 0, 1, 32'h8,        1,  1,  0, 32'h5,        1);
    add(1, 0, 1, 32'h9,        1,  1,  1, 32'h8,        2);
    add(1, 1, 1, 32'hAA,       1,  0,  0, 32'h8,        0);
    add(1, 0, 1, 32'h12,       1,  1,  0, 32'h8,        1);
    // reset mid-stream
    add(0, 0, 0, 32'h0,        1,  1,  0, 32'h0,        0);
    add(1, 0, 1, 32'h34,       1,  1,  0, 32'h0,        1);
    add(1, 0, 0, 32'h0,        1,  1,  1, 32'h34,       1);
    add(1, 0, 0, 32'h0,        1,  1,  0, 32'h34,       0);
    add(1, 0, 0, 32'h0,        1,  1,  0, 32'h34,       0);

    // reset for two cycles
    edge_s();
    edge_s();
    chk("rst_ov2",  {31'b0, ov2}, 32'h0);
    chk("rst_od2",  od2,          32'h0);
    chk("rst_occ2", {30'b0, oc2}, 32'h0);
    chk("rst_ov1",  {31'b0, ov1}, 32'h0);
    chk("rst_occ8", {28'b0, oc8}, 32'h0);
    chk("rst_od8",  od8,          32'h0);
    rst = 1'b1;
    #1;
    chk("rst_rdy2", {31'b0, ir2}, 32'h1);
    chk("rst_rdy1", {31'b0, ir1}, 32'h1);
    chk("rst_rdy8", {31'b0, ir8}, 32'h1);

    foreach (tbl[i]) begin
      rst = tbl[i].rst; fl2 = tbl[i].flush; iv2 = tbl[i].iv;
      id2 = tbl[i].d;   or2 = tbl[i].ordy;
      #1;
      chk($sformatf("rdy[%0d]", i), {31'b0, ir2}, {31'b0, tbl[i].erdy});
      edge_s();
      chk($sformatf("ov[%0d]", i),  {31'b0, ov2}, {31'b0, tbl[i].eov});
      chk($sformatf("od[%0d]", i),  od2,          tbl[i].eod);
      chk($sformatf("occ[%0d]", i), {30'b0, oc2}, tbl[i].eocc);
    end
    rst = 1'b1; fl2 = 0; iv2 = 0; or2 = 0;

    // DEPTH=1: single stallable flop
    iv1 = 1; id1 = 32'hAB; or1 = 0;
    #1; chk("d1_rdy_a", {31'b0, ir1}, 32'h1);
    edge_s();
    chk("d1_ov_a", {31'b0, ov1}, 32'h1);
    chk("d1_od_a", od1, 32'hAB);
    iv1 = 1; id1 = 32'hCD; or1 = 0;
    #1; chk("d1_rdy_full", {31'b0, ir1}, 32'h0);
    edge_s();
    chk("d1_od_hold", od1, 32'hAB);
    chk("d1_occ_hold", {31'b0, oc1}, 32'h1);
    or1 = 1;
    #1; chk("d1_rdy_pass", {31'b0, ir1}, 32'h1);
    edge_s();
    chk("d1_od_pass", od1, 32'hCD);
    chk("d1_occ_pass", {31'b0, oc1}, 32'h1);
    iv1 = 0;
    edge_s();
    chk("d1_ov_empty", {31'b0, ov1}, 32'h0);
    chk("d1_occ_empty", {31'b0, oc1}, 32'h0);
    or1 = 0;

    // DEPTH=8: fill with tail stalled, latency of eight edges
    for (int i = 0; i < 8; i++) begin
      iv8 = 1; id8 = 32'h100 + i; or8 = 0;
      #1; chk($sformatf("d8_rdy_fill%0d", i), {31'b0, ir8}, 32'h1);
      edge_s();
      chk($sformatf("d8_occ_fill%0d", i), {28'b0, oc8}, i + 1);
      chk($sformatf("d8_ov_fill%0d", i), {31'b0, ov8}, (i == 7) ? 32'h1 : 32'h0);
    end
    chk("d8_od_first", od8, 32'h100);
    id8 = 32'h1FF;
    #1; chk("d8_rdy_full", {31'b0, ir8}, 32'h0);
    edge_s();
    chk("d8_occ_full", {28'b0, oc8}, 32'h8);
    or8 = 1;
    #1; chk("d8_rdy_pass", {31'b0, ir8}, 32'h1);
    edge_s();
    chk("d8_od_pass", od8, 32'h101);
    chk("d8_occ_pass", {28'b0, oc8}, 32'h8);
    iv8 = 0;
    for (int n = 1; n <= 7; n++) begin
      edge_s();
      chk($sformatf("d8_od_drain%0d", n), od8, (n == 7) ? 32'h1FF : 32'h101 + n);
      chk($sformatf("d8_occ_drain%0d", n), {28'b0, oc8}, 8 - n);
    end
    edge_s();
    chk("d8_ov_end", {31'b0, ov8}, 32'h0);
    chk("d8_occ_end", {28'b0, oc8}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flopr_pipe.md
Name: flopr_pipe

Overview:
- Parametrised successor to the single-stage reset flop used on the multi-cycle datapath (data, RD1, RD2, ALUOut registers).
- Provides DEPTH register stages of WIDTH bits, with per-stage valid bits, valid/ready handshake, bubble collapse and synchronous flush.
- Sits between datapath producers and consumers wherever a stallable, flushable register or short elastic pipeline is needed.

Parameters:
- WIDTH, 32, data width in bits.
- DEPTH, 2, number of register stages; legal range 1..8.
- CNT_W, $clog2(DEPTH+1), width of occupancy output (derived; not overridden).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous reset, active-low; sampled on posedge clk.
- id  in  3  instance tag; used only by trace output.
- flush  in  1  synchronous clear of all valid bits.
- in_valid  in  1  producer has data.
- in_ready  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  producer data.
- out_valid  out  1  last stage holds valid data.
- out_ready  in  1  consumer accepts this cycle.
- out_data  out  WIDTH  last-stage data.
- occupancy  out  CNT_W  number of valid stages, 0..DEPTH.

Behaviour:
- Stage k holds valid[k] and data[k]. Stage 0 is the input side; stage DEPTH-1 drives out_valid and out_data.
- Reset (reset==0 at posedge): all valid[k]=0, all data[k]=0, occupancy=0. Reset overrides flush and all handshakes.
- Fires: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Advance rule, evaluated from the last stage back:
  - adv[DEPTH-1] = !valid[DEPTH-1] | out_ready.
  - adv[k] = !valid[k] | adv[k+1].
- On adv[k]: stage k loads data[k-1] and valid[k-1]. Stage 0 loads in_data and in_valid.
  - Data registers load only when the incoming valid is 1. A bubble clears the valid bit and leaves data unchanged.
- in_ready = adv[0] & !flush. This is combinational from out_ready, so there is a ready path through the block. That path is accepted for DEPTH ≤ 8.
- Bubble collapse: a stalled tail does not stall upstream stages while an empty stage exists ahead of them.
- Latency: DEPTH cycles from in_fire to out_valid when unstalled. Throughput: one word per cycle.
- out_data holds its last value while out_valid=0. Consumers must ignore it in that case.
- Flush (flush==1, reset==1):
  - All valid bits clear at the next edge and occupancy becomes 0.
  - in_ready=0, so no word is accepted in the flush cycle.
  - out_valid still reflects the current state during the flush cycle. A simultaneous out_fire counts as delivered.
- occupancy is a registered counter: +1 on in_fire, -1 on out_fire, unchanged when both occur, 0 on flush or reset.
  - Invariant: occupancy equals popcount(valid) at every cycle.
- Full: occupancy==DEPTH and out_ready==0 → in_ready=0.
- Full: occupancy==DEPTH and out_ready==1 → in_ready=1, pass-through at full rate.
- Empty: out_valid=0; out_ready is ignored.
- DEPTH==1 degenerates to a single stallable flop with valid bit.

Optional Feature:
- Macro: FLOPR_PIPE_TRACE_EN.
- Defined: on each in_fire and out_fire the block prints a simulation trace line containing the label, occupancy and data in hex.
  - Label by id: 000 DATA, 001 RD1, 010 RD2, 011 ALUOut, otherwise PIPE.
  - A flush that drops valid words also prints one line with the number of words dropped.
- Undefined: no display statements and no extra logic; fully synthesizable. Functional behaviour is identical either way.

Decomposition:
- Package flopr_pkg:
  - ID constants FLOPR_ID_DATA=3'b000, FLOPR_ID_RD1=3'b001, FLOPR_ID_RD2=3'b010, FLOPR_ID_ALUOUT=3'b011.
  - Label function mapping id to string, used under the trace macro only.
  - DEPTH legality limit FLOPR_PIPE_MAX_DEPTH=8.
- Sub-module flopr_pipe_stage: one valid+data register with inputs load, flush, d_valid, d_data. Instantiated DEPTH times via generate.
- Top level holds the advance chain, occupancy counter and trace.

Test Plan:
- Reset and ready: reset=0 for 2 cycles, then 1 → out_valid=0, out_data=0, occupancy=0, in_ready=1.
- Streaming (DEPTH=2, out_ready=1): push 0x11111111, 0x22222222, 0x33333333 on consecutive cycles → out_valid first at cycle 2 after the first accept, words emerge in order on consecutive cycles, occupancy peaks at 2.
- Back-pressure, full and bubble collapse:
  - Hold out_ready=0 and push 0xA, 0xB → occupancy=2, in_ready=0, and 0xC is held by the producer.
  - Raise out_ready for one cycle → 0xA delivered; 0xC accepted in that same cycle; occupancy stays 2.
- Bubble collapse with a gap: push 0x5, idle one cycle, push 0x6, with out_ready=0 throughout → both stages fill, occupancy=2, no gap retained.
- Flush: with occupancy=2, assert flush with in_valid=1 and data 0x7 → in_ready=0, next cycle out_valid=0, occupancy=0, and 0x7 never appears at the output.
- Reset mid-stream: drive reset=0 while occupancy=1 and out_ready=1 → next cycle all stages invalid, data=0. Repeat with DEPTH=1 and DEPTH=8 builds, and with FLOPR_PIPE_TRACE_EN both defined and undefined; output streams must match.
